// File: rtl/feedback_tx_pkg.sv
// Field layout and memory map for the node-to-node feedback packet.
// Shared with the receive side so both agree on word order and header bits.
package feedback_tx_pkg;

   localparam int                    WORD_WIDTH     = 16;
   localparam int                    CNT_W          = 5;
   localparam logic [WORD_WIDTH-1:0] MAX_SINKS      = 16'd16;
   localparam logic [WORD_WIDTH-1:0] KSINK_BASE     = 16'h0008;
   localparam logic [WORD_WIDTH-1:0] KSINK_CNT_ADDR = 16'h0688;
   localparam logic [3:0]            PKT_TYPE       = 4'hA;
   localparam logic [2:0]            LAST_HDR_IDX   = 3'd6;
   localparam logic [7:0]            HDR_LEN_BASE   = 8'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_CNT,
      S_WAIT_CNT,
      S_SEND_HDR,
      S_RD_SINK,
      S_WAIT_SINK,
      S_SEND_SINK,
      S_DONE
   } state_t;

   // Raw count is compared on all 16 bits so large values clamp instead of wrapping.
   function automatic logic [CNT_W-1:0] clamp_count(input logic [WORD_WIDTH-1:0] raw);
      return (raw > MAX_SINKS) ? MAX_SINKS[CNT_W-1:0] : raw[CNT_W-1:0];
   endfunction

   function automatic logic [WORD_WIDTH-1:0] header_word(input logic agg,
                                                         input logic [CNT_W-1:0] n);
      logic [7:0] len;
      len = HDR_LEN_BASE + {3'b000, n};
      return {PKT_TYPE, agg, 3'b000, len};
   endfunction

   function automatic logic [WORD_WIDTH-1:0] sink_addr(input logic [3:0] s);
      return KSINK_BASE + {11'd0, s, 1'b0};
   endfunction

endpackage

// File: rtl/feedback_tx_if.sv
// Memory read port plus valid/ready word stream toward the link layer.
interface feedback_tx_if;
   import feedback_tx_pkg::*;

   logic [WORD_WIDTH-1:0] address;
   logic                  wr_en;
   logic [WORD_WIDTH-1:0] mem_data_out;
   logic [WORD_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  tx_last;

   modport master (
      output address, wr_en, tx_data, tx_valid, tx_last,
      input  mem_data_out, tx_ready
   );

   modport slave (
      input  address, wr_en, tx_data, tx_valid, tx_last,
      output mem_data_out, tx_ready
   );

endinterface

// File: rtl/feedback_tx.sv
// Builds and serialises the feedback packet after action selection completes.
//
// state       | meaning
// S_IDLE      | wait for en & start; latch node registers
// S_RD_CNT    | knownSinkCount address on the bus
// S_WAIT_CNT  | capture clamped count, load header word 0
// S_SEND_HDR  | present header words 0..6
// S_RD_SINK   | knownSinks[s] address on the bus
// S_WAIT_SINK | capture sink word into the output register
// S_SEND_SINK | present sink word s
// S_DONE      | packet complete, done asserted
module feedback_tx
   import feedback_tx_pkg::*;
(
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] my_node_id,
   input  logic [WORD_WIDTH-1:0] my_cluster_id,
   input  logic [WORD_WIDTH-1:0] my_battery_stat,
   input  logic [WORD_WIDTH-1:0] my_best,
   input  logic [WORD_WIDTH-1:0] next_hop,
   input  logic                  for_aggregation,
   output logic                  done,
   feedback_tx_if.master         bus
);

   state_t                state_q, state_d;
   logic [2:0]            idx_q, idx_d, idx_inc;
   logic [3:0]            s_q, s_d;
   logic [CNT_W-1:0]      n_q, n_d;
   logic [WORD_WIDTH-1:0] node_q, node_d, hop_q, hop_d, bat_q, bat_d;
   logic [WORD_WIDTH-1:0] best_q, best_d, clu_q, clu_d;
   logic                  agg_q, agg_d;
   logic [WORD_WIDTH-1:0] address_q, address_d, tx_data_q, tx_data_d, hdr_next;
   logic                  tx_valid_q, tx_valid_d, tx_last_q, tx_last_d, done_q, done_d;
   logic                  last_sink;

   assign idx_inc   = idx_q + 3'd1;
   assign last_sink = ({1'b0, s_q} == (n_q - 5'd1));

   always_comb begin
      hdr_next = '0;
      case (idx_inc)
         3'd1:    hdr_next = node_q;
         3'd2:    hdr_next = hop_q;
         3'd3:    hdr_next = bat_q;
         3'd4:    hdr_next = best_q;
         3'd5:    hdr_next = clu_q;
         3'd6:    hdr_next = {11'd0, n_q};
         default: hdr_next = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      s_d        = s_q;
      n_d        = n_q;
      node_d     = node_q;
      hop_d      = hop_q;
      bat_d      = bat_q;
      best_d     = best_q;
      clu_d      = clu_q;
      agg_d      = agg_q;
      address_d  = address_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      tx_last_d  = tx_last_q;
      done_d     = done_q;
      case (state_q)
         S_IDLE: begin
            if (en && start) begin
               node_d    = my_node_id;
               hop_d     = next_hop;
               bat_d     = my_battery_stat;
               best_d    = my_best;
               clu_d     = my_cluster_id;
               agg_d     = for_aggregation;
               done_d    = 1'b0;
               address_d = KSINK_CNT_ADDR;
               state_d   = S_RD_CNT;
            end
         end
         S_RD_CNT: state_d = S_WAIT_CNT;
         S_WAIT_CNT: begin
            n_d        = clamp_count(bus.mem_data_out);
            idx_d      = '0;
            s_d        = '0;
            tx_data_d  = header_word(agg_q, n_d);
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
            state_d    = S_SEND_HDR;
         end
         S_SEND_HDR: begin
            if (bus.tx_ready) begin
               if (idx_q == LAST_HDR_IDX) begin
                  tx_valid_d = 1'b0;
                  tx_last_d  = 1'b0;
                  if (n_q != '0) begin
                     address_d = sink_addr(s_q);
                     state_d   = S_RD_SINK;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end else begin
                  idx_d     = idx_inc;
                  tx_data_d = hdr_next;
                  // Word 6 closes the packet only when there are no sinks to follow.
                  tx_last_d = (idx_inc == LAST_HDR_IDX) && (n_q == '0);
               end
            end
         end
         S_RD_SINK: state_d = S_WAIT_SINK;
         S_WAIT_SINK: begin
            tx_data_d  = bus.mem_data_out;
            tx_valid_d = 1'b1;
            tx_last_d  = last_sink;
            state_d    = S_SEND_SINK;
         end
         S_SEND_SINK: begin
            if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               if (last_sink) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  s_d       = s_q + 4'd1;
                  address_d = sink_addr(s_q + 4'd1);
                  state_d   = S_RD_SINK;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         s_q        <= '0;
         n_q        <= '0;
         node_q     <= '0;
         hop_q      <= '0;
         bat_q      <= '0;
         best_q     <= '0;
         clu_q      <= '0;
         agg_q      <= 1'b0;
         address_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         s_q        <= s_d;
         n_q        <= n_d;
         node_q     <= node_d;
         hop_q      <= hop_d;
         bat_q      <= bat_d;
         best_q     <= best_d;
         clu_q      <= clu_d;
         agg_q      <= agg_d;
         address_q  <= address_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
         done_q     <= done_d;
      end
   end

   assign bus.address  = address_q;
   assign bus.wr_en    = 1'b0;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_last  = tx_last_q;
   assign done         = done_q;

endmodule
